// File: rtl/block_grid_scanout_pkg.sv
// Shared constants for the block grid: block codes, colours, VGA timing and grid geometry.
// Used by the scanout, the game-logic writer and the block-map RAM.
package block_grid_scanout_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int CELL_SHIFT  = 3;
  localparam int GRID_WIDTH  = VGA_H_VISIBLE >> CELL_SHIFT;
  localparam int GRID_HEIGHT = VGA_V_VISIBLE >> CELL_SHIFT;
  localparam int GRID_CELLS  = GRID_WIDTH * GRID_HEIGHT;
  localparam int ADDR_W      = 13;
  localparam int CNT_W       = 10;

  typedef enum logic [1:0] {
    BLOCK_EMPTY = 2'd0,
    BLOCK_WALL  = 2'd1,
    BLOCK_SNAKE = 2'd2,
    BLOCK_FOOD  = 2'd3
  } block_t;

  localparam logic [7:0] COLOR_EMPTY = 8'h00;
  localparam logic [7:0] COLOR_WALL  = 8'hFF;
  localparam logic [7:0] COLOR_SNAKE = 8'h1C;
  localparam logic [7:0] COLOR_FOOD  = 8'hE0;

  // Per-pixel control flags that travel alongside the RAM read.
  typedef struct packed {
    logic visible;
    logic hsync;
    logic vsync;
    logic vblank;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{visible: 1'b0, hsync: 1'b1, vsync: 1'b1, vblank: 1'b0};

  function automatic logic [7:0] block_color(input logic [1:0] code);
    case (block_t'(code))
      BLOCK_WALL:  return COLOR_WALL;
      BLOCK_SNAKE: return COLOR_SNAKE;
      BLOCK_FOOD:  return COLOR_FOOD;
      default:     return COLOR_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/block_grid_scanout_if.sv
// Block-map read port plus VGA output bundle of the scanout.
interface block_grid_scanout_if;
  import block_grid_scanout_pkg::*;

  logic [ADDR_W-1:0] RdAddr;
  logic [1:0]        RdData;
  logic [7:0]        RGB;
  logic              HSync;
  logic              VSync;
  logic              VBlankStart;

  modport master (output RdAddr, RGB, HSync, VSync, VBlankStart, input RdData);
  modport slave  (input RdAddr, RGB, HSync, VSync, VBlankStart, output RdData);
endinterface

// File: rtl/block_grid_scanout_timing.sv
// VGA raster counters with raw (undelayed) sync, visible and vblank-start flags.
module vga_timing_gen
  import block_grid_scanout_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic             Clock,
  input  logic             ResetN,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             line_end,
  output logic             frame_end,
  output stage_t           flags
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values,
  // and the reset sits in the sensitivity list so it acts without waiting for a clock.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      hcount <= '0;
      vcount <= '0;
    end else if (line_end) begin
      hcount <= '0;
      vcount <= frame_end ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  // NOTE: every output is assigned unconditionally here, so no latch can be inferred.
  always_comb begin
    line_end      = (hcount == H_LAST);
    frame_end     = line_end && (vcount == V_LAST);
    flags.visible = (hcount < H_VIS) && (vcount < V_VIS);
    flags.hsync   = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
    flags.vsync   = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
    flags.vblank  = (hcount == '0) && (vcount == V_VIS);
  end

endmodule

// File: rtl/block_grid_scanout.sv
// Scans the block-map RAM in raster order and turns 2-bit block codes into VGA colour.
// RGB, HSync, VSync and VBlankStart all trail the counters by three cycles.
module block_grid_scanout
  import block_grid_scanout_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input logic                  Clock,
  input logic                  ResetN,
  block_grid_scanout_if.master bus
);

  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(H_VISIBLE >> CELL_SHIFT);
  localparam logic [CNT_W-1:0]  V_VIS_LAST = CNT_W'(V_VISIBLE - 1);

  logic [CNT_W-1:0]  hcount;
  logic [CNT_W-1:0]  vcount;
  logic              line_end;
  logic              frame_end;
  stage_t            raw;
  stage_t            d1;
  stage_t            d2;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col;

  vga_timing_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .hcount   (hcount),
    .vcount   (vcount),
    .line_end (line_end),
    .frame_end(frame_end),
    .flags    (raw)
  );

  assign col = ADDR_W'(hcount >> CELL_SHIFT);

  // Row base steps once per cell row; the last visible line leaves it on the final row.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      row_base <= '0;
    end else if (frame_end) begin
      row_base <= '0;
    end else if (line_end && (&vcount[CELL_SHIFT-1:0]) && (vcount < V_VIS_LAST)) begin
      row_base <= row_base + ROW_STEP;
    end
  end

  // Blanking reads park on address 0 so the RAM never sees an out-of-range address.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      bus.RdAddr <= '0;
      d1         <= STAGE_IDLE;
      d2         <= STAGE_IDLE;
    end else begin
      bus.RdAddr <= raw.visible ? row_base + col : '0;
      d1         <= raw;
      d2         <= d1;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      bus.RGB         <= COLOR_EMPTY;
      bus.HSync       <= 1'b1;
      bus.VSync       <= 1'b1;
      bus.VBlankStart <= 1'b0;
    end else begin
      bus.RGB         <= d2.visible ? block_color(bus.RdData) : COLOR_EMPTY;
      bus.HSync       <= d2.hsync;
      bus.VSync       <= d2.vsync;
      bus.VBlankStart <= d2.vblank;
    end
  end

endmodule
